// File: rtl/pipe_stage_reg.sv
// One pipeline stage: a valid bit plus a payload register.
// Priority: reset, then clear, then load; otherwise the stage holds.
// Clear drops only the valid bit so the payload stays untouched.
module pipe_stage_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // Next-state selection: clear wins over load, and data moves only on load.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = valid_i;
            data_d  = data_i;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Chain of DEPTH valid/data stages with a valid/ready handshake.
// The ready path is combinational from out_ready back to in_ready, so an
// empty stage always pulls from upstream and bubbles close under a stall.
module pipe_stage_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    if (DEPTH < 1) begin : g_depth_check
        $error("pipe_stage_chain: DEPTH must be >= 1");
    end

    logic [DEPTH:0]   ready;
    logic [DEPTH-1:0] stage_valid;
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic             accept;
    logic [OCC_W-1:0] occ_d;

    // Ready chain: a stage can load if it is empty or its successor moves.
    always_comb begin
        ready[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            ready[i] = !stage_valid[i] || ready[i+1];
        end
    end

    assign in_ready = ready[0] && !flush && !reset;
    assign accept   = in_valid && in_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;

        if (g == 0) begin : g_head
            assign up_valid = accept;
            assign up_data  = in_data;
        end else begin : g_body
            assign up_valid = stage_valid[g-1];
            assign up_data  = stage_data[g-1];
        end

        pipe_stage_reg #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk_i   (clk),
            .reset_i (reset),
            .clear_i (flush),
            .load_i  (ready[g]),
            .valid_i (up_valid),
            .data_i  (up_data),
            .valid_o (stage_valid[g]),
            .data_o  (stage_data[g])
        );
    end

    // Occupancy is the popcount of the registered valid bits.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCC_W'(stage_valid[i]);
        end
    end

    assign occupancy = occ_d;
    assign out_valid = stage_valid[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain with WIDTH=8, DEPTH=3.
module tb_pipe_stage_chain;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             reset, flush, in_valid, out_ready;
    logic             in_ready, out_valid;
    logic [WIDTH-1:0] in_data, out_data;
    logic [1:0]       occupancy;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       rst;
        logic       fl;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [1:0] e_occ;
        logic       chk_st;
        logic       chk_od;
    } vec_t;

    localparam int NVEC = 28;
    vec_t vecs [NVEC];

    pipe_stage_chain #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic fl, logic iv, logic [7:0] id, logic ordy,
                                logic e_ir, logic e_ov, logic [7:0] e_od, logic [1:0] e_occ,
                                logic chk_st, logic chk_od);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
        v.chk_st = chk_st; v.chk_od = chk_od;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic iv,
                         input logic [7:0] id, input logic ordy);
        reset = rst; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, streaming, backpressure and bubble collapse.
        vecs[0]  = mk(1,0,1,8'h00,1, 0,0,8'h00,0, 0,0);
        vecs[1]  = mk(1,0,1,8'h00,1, 0,0,8'h00,0, 1,1);
        vecs[2]  = mk(0,0,0,8'h00,1, 1,0,8'h00,0, 1,1);
        vecs[3]  = mk(0,0,1,8'h11,1, 1,0,8'h00,0, 1,0);
        vecs[4]  = mk(0,0,1,8'h22,1, 1,0,8'h00,1, 1,0);
        vecs[5]  = mk(0,0,1,8'h33,1, 1,0,8'h00,2, 1,0);
        vecs[6]  = mk(0,0,1,8'h44,1, 1,1,8'h11,3, 1,1);
        vecs[7]  = mk(0,0,0,8'h00,1, 1,1,8'h22,3, 1,1);
        vecs[8]  = mk(0,0,0,8'h00,1, 1,1,8'h33,2, 1,1);
        vecs[9]  = mk(0,0,0,8'h00,1, 1,1,8'h44,1, 1,1);
        vecs[10] = mk(0,0,0,8'h00,1, 1,0,8'h00,0, 1,0);
        vecs[11] = mk(0,0,1,8'hA1,0, 1,0,8'h00,0, 1,0);
        vecs[12] = mk(0,0,1,8'hA2,0, 1,0,8'h00,1, 1,0);
        vecs[13] = mk(0,0,1,8'hA3,0, 1,0,8'h00,2, 1,0);
        vecs[14] = mk(0,0,1,8'hA4,0, 0,1,8'hA1,3, 1,1);
        vecs[15] = mk(0,0,1,8'hA4,0, 0,1,8'hA1,3, 1,1);
        vecs[16] = mk(0,0,1,8'hA4,1, 1,1,8'hA1,3, 1,1);
        vecs[17] = mk(0,0,0,8'h00,1, 1,1,8'hA2,3, 1,1);
        vecs[18] = mk(0,0,0,8'h00,1, 1,1,8'hA3,2, 1,1);
        vecs[19] = mk(0,0,0,8'h00,1, 1,1,8'hA4,1, 1,1);
        vecs[20] = mk(0,0,1,8'h55,0, 1,0,8'h00,0, 1,0);
        vecs[21] = mk(0,0,0,8'h00,0, 1,0,8'h00,1, 1,0);
        vecs[22] = mk(0,0,1,8'h66,0, 1,0,8'h00,1, 1,0);
        vecs[23] = mk(0,0,0,8'h00,0, 1,1,8'h55,2, 1,1);
        vecs[24] = mk(0,0,0,8'h00,0, 1,1,8'h55,2, 1,1);
        vecs[25] = mk(0,0,0,8'h00,1, 1,1,8'h55,2, 1,1);
        vecs[26] = mk(0,0,0,8'h00,1, 1,1,8'h66,1, 1,1);
        vecs[27] = mk(0,0,0,8'h00,1, 1,0,8'h00,0, 1,0);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
            check("in_ready", i, 32'(in_ready), 32'(vecs[i].e_ir));
            if (vecs[i].chk_st) begin
                check("out_valid", i, 32'(out_valid), 32'(vecs[i].e_ov));
                check("occupancy", i, 32'(occupancy), 32'(vecs[i].e_occ));
            end
            if (vecs[i].chk_od) begin
                check("out_data", i, 32'(out_data), 32'(vecs[i].e_od));
            end
            tick();
        end

        // Flush of a full chain with a competing input.
        drive(0,0,1,8'hB1,0); tick();
        drive(0,0,1,8'hB2,0); tick();
        drive(0,0,1,8'hB3,0); tick();
        drive(0,1,1,8'h77,0);
        check("flush_in_ready", 100, 32'(in_ready), 32'd0);
        check("flush_pre_occ",  100, 32'(occupancy), 32'd3);
        check("flush_pre_od",   100, 32'(out_data), 32'hB1);
        tick();
        drive(0,0,0,8'h00,1);
        check("flush_occ",      101, 32'(occupancy), 32'd0);
        check("flush_ov",       101, 32'(out_valid), 32'd0);
        check("flush_in_ready", 101, 32'(in_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("flush_no_77", 102 + k, 32'(out_valid), 32'd0);
        end

        // Reset together with flush while two entries are held.
        drive(0,0,1,8'hD1,1); tick();
        drive(0,0,1,8'hD2,1); tick();
        drive(0,0,0,8'h00,1);
        check("mid_occ", 110, 32'(occupancy), 32'd2);
        drive(1,1,1,8'hEE,1);
        check("rst_in_ready", 111, 32'(in_ready), 32'd0);
        tick();
        drive(0,0,1,8'hC3,1);
        check("rst_ov",       112, 32'(out_valid), 32'd0);
        check("rst_od",       112, 32'(out_data), 32'h00);
        check("rst_occ",      112, 32'(occupancy), 32'd0);
        check("rst_in_ready", 112, 32'(in_ready), 32'd1);
        tick();
        drive(0,0,0,8'h00,1);
        check("c3_ov1",  113, 32'(out_valid), 32'd0);
        check("c3_occ1", 113, 32'(occupancy), 32'd1);
        tick();
        check("c3_ov2",  114, 32'(out_valid), 32'd0);
        tick();
        check("c3_ov3",  115, 32'(out_valid), 32'd1);
        check("c3_od3",  115, 32'(out_data), 32'hC3);
        check("c3_occ3", 115, 32'(occupancy), 32'd1);
        tick();
        check("c3_alone_ov",  116, 32'(out_valid), 32'd0);
        check("c3_alone_occ", 116, 32'(occupancy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
